// File: rtl/vc_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vc_arb_pkg                                                         |
// | Shared helpers and types for the round-robin arbiter family.       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package vc_arb_pkg;

  localparam int c_max_reqs  = 16;
  localparam int c_ptr_reset = 0;

  typedef logic [c_max_reqs-1:0] onehot_t;

  // Index width clamped to at least one bit so single-entry users still get a port.
  function automatic int clog2_clamp(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vc_rr_arbiter                                                      |
// | Round-robin priority search with a rotating pointer register.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module vc_rr_arbiter
  import vc_arb_pkg::*;
#(
  parameter  int p_nreqs     = 4,
  localparam int c_sel_nbits = clog2_clamp(p_nreqs)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_nreqs-1:0]     req,
  input  logic                   en,
  output logic [p_nreqs-1:0]     grant,
  output logic [c_sel_nbits-1:0] grant_idx
);

  localparam int c_sum_nbits = c_sel_nbits + 1;

  logic [c_sel_nbits-1:0] r_ptr;
  logic [c_sum_nbits-1:0] w_probe;
  logic                   w_found;

  // Walk indices ptr, ptr+1, ... modulo p_nreqs; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_probe   = '0;
    for (int k = 0; k < p_nreqs; k++) begin
      w_probe = {1'b0, r_ptr} + c_sum_nbits'(k);
      if (w_probe >= c_sum_nbits'(p_nreqs)) begin
        w_probe = w_probe - c_sum_nbits'(p_nreqs);
      end
      if (!w_found && req[w_probe[c_sel_nbits-1:0]]) begin
        w_found   = 1'b1;
        grant_idx = w_probe[c_sel_nbits-1:0];
      end
    end
    if (w_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= c_sel_nbits'(c_ptr_reset);
    end else if (en) begin
      r_ptr <= (grant_idx == c_sel_nbits'(p_nreqs - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vc_rr_arb_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vc_rr_arb_mux                                                      |
// | N-input val/rdy stream mux, round-robin select, registered output. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module vc_rr_arb_mux
  import vc_arb_pkg::*;
#(
  parameter  int p_nbits     = 32,
  parameter  int p_nreqs     = 4,
  localparam int c_sel_nbits = clog2_clamp(p_nreqs)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_nreqs-1:0]         in_val,
  output logic [p_nreqs-1:0]         in_rdy,
  input  logic [p_nreqs*p_nbits-1:0] in_msg,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [p_nbits-1:0]         out_msg,
  output logic [c_sel_nbits-1:0]     out_src
);

  logic                   r_full;
  logic [p_nbits-1:0]     r_msg;
  logic [c_sel_nbits-1:0] r_src;

  logic [p_nreqs-1:0]     w_grant;
  logic [c_sel_nbits-1:0] w_idx;
  logic                   w_can_accept;
  logic                   w_xfer;
  logic [p_nbits-1:0]     w_sel_msg;

  // Reset gating keeps in_rdy low while reset is held, even with a free slot.
  assign w_can_accept = !reset && (!r_full || out_rdy);
  assign w_xfer       = w_can_accept && (|in_val);
  assign in_rdy       = w_grant & {p_nreqs{w_can_accept}};

  // Only the winner's slice is selected, so X on other streams never reaches r_msg.
  assign w_sel_msg = in_msg[int'(w_idx)*p_nbits +: p_nbits];

  vc_rr_arbiter #(
    .p_nreqs   (p_nreqs)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_val),
    .en        (w_xfer),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_msg  <= '0;
      r_src  <= '0;
    end else if (w_xfer) begin
      r_full <= 1'b1;
      r_msg  <= w_sel_msg;
      r_src  <= w_idx;
    end else if (out_rdy) begin
      r_full <= 1'b0;
    end
  end

  assign out_val = r_full;
  assign out_msg = r_msg;
  assign out_src = r_src;

endmodule
`default_nettype wire

// File: tb/tb_vc_rr_arb_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vc_rr_arb_mux                                                   |
// | Bench for vc_rr_arb_mux at 4, 2 and 5 inputs with a shared model.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_vc_rr_arb_mux;

  logic        clk;
  logic        reset;
  logic        out_rdy;
  logic [4:0]  in_val_all;
  logic [31:0] msgs [5];

  logic [3:0]  rdy4;  logic val4; logic [31:0] msg4; logic [1:0] src4;
  logic [1:0]  rdy2;  logic val2; logic [31:0] msg2; logic [0:0] src2;
  logic [4:0]  rdy5;  logic val5; logic [31:0] msg5; logic [2:0] src5;

  logic [127:0] in_msg4;
  logic [63:0]  in_msg2;
  logic [159:0] in_msg5;
  assign in_msg4 = {msgs[3], msgs[2], msgs[1], msgs[0]};
  assign in_msg2 = {msgs[1], msgs[0]};
  assign in_msg5 = {msgs[4], msgs[3], msgs[2], msgs[1], msgs[0]};

  vc_rr_arb_mux #(.p_nbits(32), .p_nreqs(4)) dut4 (
    .clk(clk), .reset(reset), .in_val(in_val_all[3:0]), .in_rdy(rdy4), .in_msg(in_msg4),
    .out_val(val4), .out_rdy(out_rdy), .out_msg(msg4), .out_src(src4));
  vc_rr_arb_mux #(.p_nbits(32), .p_nreqs(2)) dut2 (
    .clk(clk), .reset(reset), .in_val(in_val_all[1:0]), .in_rdy(rdy2), .in_msg(in_msg2),
    .out_val(val2), .out_rdy(out_rdy), .out_msg(msg2), .out_src(src2));
  vc_rr_arb_mux #(.p_nbits(32), .p_nreqs(5)) dut5 (
    .clk(clk), .reset(reset), .in_val(in_val_all), .in_rdy(rdy5), .in_msg(in_msg5),
    .out_val(val5), .out_rdy(out_rdy), .out_msg(msg5), .out_src(src5));

  logic [4:0]  act_rdy [3];
  logic        act_val [3];
  logic [31:0] act_msg [3];
  logic [2:0]  act_src [3];
  assign act_rdy[0] = {1'b0, rdy4}; assign act_val[0] = val4; assign act_msg[0] = msg4; assign act_src[0] = {1'b0, src4};
  assign act_rdy[1] = {3'b0, rdy2}; assign act_val[1] = val2; assign act_msg[1] = msg2; assign act_src[1] = {2'b0, src2};
  assign act_rdy[2] = rdy5;         assign act_val[2] = val5; assign act_msg[2] = msg5; assign act_src[2] = src5;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, next-search pointer and captured message per instance.
  int          n      [3] = '{4, 2, 5};
  bit          m_full [3];
  int          m_ptr  [3];
  logic [31:0] m_msg  [3];
  int          m_src  [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 0; m_ptr[i] = 0; m_msg[i] = 32'h0; m_src[i] = 0;
    end
  endtask

  function automatic int winner(input int i);
    for (int k = 0; k < n[i]; k++) begin
      int j = (m_ptr[i] + k) % n[i];
      if (in_val_all[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if (reset) return;
    for (int i = 0; i < 3; i++) begin
      int w = winner(i);
      if (w >= 0 && (!m_full[i] || out_rdy)) begin
        m_full[i] = 1; m_msg[i] = msgs[w]; m_src[i] = w; m_ptr[i] = (w + 1) % n[i];
      end else if (out_rdy && m_full[i]) begin
        m_full[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int w = winner(i);
      logic [4:0] e_rdy = '0;
      if (!reset && w >= 0 && (!m_full[i] || out_rdy)) e_rdy[w] = 1'b1;
      chk($sformatf("n%0d in_rdy", n[i]), {27'b0, act_rdy[i]}, {27'b0, e_rdy});
      chk($sformatf("n%0d out_val", n[i]), {31'b0, act_val[i]}, {31'b0, m_full[i]});
      chk($sformatf("n%0d out_msg", n[i]), act_msg[i], m_msg[i]);
      chk($sformatf("n%0d out_src", n[i]), {29'b0, act_src[i]}, 32'(m_src[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic [3:0]  val;
    logic        rdy;
    logic [3:0]  e_rdy;
    logic        e_val;
    logic [1:0]  e_src;
    logic [31:0] e_msg;
  } vec_t;
  vec_t tbl [16];

  initial begin
    // Round robin, sparse wrap, backpressure, drain, refill from empty.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h00};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h10};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 32'h11};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 32'h12};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 32'h13};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0, 32'h10};
    tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2, 32'h12};
    tbl[7]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h10};
    tbl[8]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h10};
    tbl[9]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd0, 32'h10};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 32'h11};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h11};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 32'h11};
    tbl[13] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 2'd1, 32'h11};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h13};
    tbl[15] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h13};

    reset = 1'b1; out_rdy = 1'b0; in_val_all = '0;
    for (int i = 0; i < 5; i++) msgs[i] = 32'h10 + 32'(i);
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;

    for (int v = 0; v < 16; v++) begin
      in_val_all = {1'b0, tbl[v].val};
      out_rdy    = tbl[v].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d in_rdy", v),  {28'b0, rdy4}, {28'b0, tbl[v].e_rdy});
      chk($sformatf("vec%0d out_val", v), {31'b0, val4}, {31'b0, tbl[v].e_val});
      chk($sformatf("vec%0d out_src", v), {30'b0, src4}, {30'b0, tbl[v].e_src});
      chk($sformatf("vec%0d out_msg", v), msg4, tbl[v].e_msg);
      check_all();
      tick();
    end

    // Load a known word, then reset asynchronously in mid-cycle.
    in_val_all = 5'b00001; msgs[0] = 32'hDEAD_BEEF; out_rdy = 1'b1;
    @(negedge clk); check_all(); tick();
    chk("preload out_msg", msg4, 32'hDEAD_BEEF);
    in_val_all = 5'b0; out_rdy = 1'b0;
    #2;
    reset = 1'b1; model_reset();
    #1;
    chk("async rst out_val", {31'b0, val4}, 32'h0);
    chk("async rst out_msg", msg4, 32'h0);
    chk("async rst out_src", {30'b0, src4}, 32'h0);
    in_val_all = 5'b11111;
    for (int i = 0; i < 5; i++) msgs[i] = 32'h10 + 32'(i);
    @(negedge clk);
    chk("in_rdy during rst", {28'b0, rdy4}, 32'h0);
    check_all();
    tick();
    reset = 1'b0; out_rdy = 1'b1;
    @(negedge clk);
    chk("post rst in_rdy", {28'b0, rdy4}, 32'h1);
    check_all(); tick();

    // Single requester, then wrap from pointer 3 with sparse requests.
    in_val_all = 5'b00100; msgs[2] = 32'h0000_00A5;
    @(negedge clk);
    chk("post rst out_src", {30'b0, src4}, 32'h0);
    chk("single in_rdy", {28'b0, rdy4}, 32'h4);
    check_all(); tick();
    in_val_all = 5'b00011;
    @(negedge clk);
    chk("single out_msg", msg4, 32'hA5);
    chk("single out_src", {30'b0, src4}, 32'h2);
    chk("wrap in_rdy", {28'b0, rdy4}, 32'h1);
    check_all(); tick();
    @(negedge clk);
    chk("wrap out_src", {30'b0, src4}, 32'h0);
    chk("wrap next in_rdy", {28'b0, rdy4}, 32'h2);
    check_all(); tick();
    in_val_all = 5'b0;
    @(negedge clk);
    chk("wrap next out_src", {30'b0, src4}, 32'h1);
    check_all(); tick();

    // Random traffic; idle streams sometimes carry X to prove it is never captured.
    for (int c = 0; c < 400; c++) begin
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        model_reset();
      end
      in_val_all = 5'($urandom);
      out_rdy    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 5; i++) begin
        if (!in_val_all[i] && $urandom_range(0, 3) == 0) msgs[i] = 'x;
        else msgs[i] = $urandom;
      end
      @(negedge clk);
      check_all();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vc_rr_arb_mux.md
Name: vc_rr_arb_mux

Overview:
Parametrised N-input stream mux that replaces a fixed-select mux wherever several val/rdy producers share one consumer.
Selects one valid input per cycle by round-robin arbitration and captures the winning message plus its source index in a single output pipeline register.
The output register sustains full throughput (one message per cycle) under continuous out_rdy.
Used in front of shared memory/response ports in the processor and cache subsystems.

Parameters:
p_nbits, 32, message width in bits (>=1)
p_nreqs, 4, number of input streams (2..16)
c_sel_nbits, $clog2(p_nreqs), derived localparam, width of the source index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_val  input  p_nreqs  per-input valid; bit i belongs to stream i
in_rdy  output  p_nreqs  per-input ready; at most one bit high per cycle
in_msg  input  p_nreqs*p_nbits  flattened messages; stream i occupies bits [i*p_nbits +: p_nbits]
out_val  output  1  output register holds a message
out_rdy  input  1  consumer ready
out_msg  output  p_nbits  registered message
out_src  output  c_sel_nbits  index of the stream that produced out_msg

Behaviour:
- Reset (asynchronous, takes effect without a clock edge): full=0, prio_ptr=0, out_msg=0, out_src=0. While reset is high: out_val=0 and in_rdy=0.
- Reset mid-operation discards the held message. The first grant after reset release starts the search at stream 0.
- can_accept = !full || out_rdy (combinational).
- Arbitration (combinational):
  - Search in_val from index prio_ptr upward, wrapping modulo p_nreqs.
  - The first set bit is the winner w. If in_val==0, there is no winner.
- in_rdy[w] = can_accept; all other in_rdy bits = 0.
  - in_rdy never depends on in_val of the same stream beyond the winner selection.
  - in_rdy is never high for a non-valid stream.
- Input transfer occurs when in_val[w] && in_rdy[w]. On that clock edge:
  - out_msg <= in_msg[w]
  - out_src <= w
  - full <= 1
  - prio_ptr <= (w+1) mod p_nreqs (wraps from p_nreqs-1 to 0)
- If there is no input transfer and out_rdy && full: full <= 0. out_msg and out_src hold their last value.
- If there is no transfer and out_rdy=0: all state holds, so out_msg and out_src are stable while out_val && !out_rdy.
- Simultaneous output dequeue and input transfer: full stays 1 and the new message replaces the old one in the same edge. This gives one message per cycle.
- out_val = full.
- Latency: exactly 1 cycle from input transfer to out_val.
- prio_ptr changes only on an input transfer. A losing stream waits at most p_nreqs-1 grants (starvation-free).
- Messages pass unmodified; there is no width conversion.
- X on in_msg of a non-granted stream must not propagate to out_msg.

Decomposition:
- Shared package vc_arb_pkg:
  - function for the clamped index width: max(1, $clog2(n))
  - typedef for one-hot grant vectors
  - localparam for the reset pointer value (0)
- Natural sub-module: vc_rr_arbiter. It holds the combinational rotate/priority-encode plus the prio_ptr register.
  - Inputs: clk, reset, req, en.
  - Outputs: grant one-hot, grant_idx.
  - It is reusable by future arbitrated crossbars.
- The top level holds the output register, the full flag and the message select, built as an indexed part-select over in_msg.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert reset while out_val=1 and out_msg=0xDEAD_BEEF, with no clock edge.
  - Required: out_val=0, out_msg=0, out_src=0 immediately; in_rdy=0 during reset.
  - After release with in_val=4'b1111: first out_src=0.
- Single requester:
  - Stimulus: in_val=4'b0100, in_msg[2]=0x0000_00A5, out_rdy=1.
  - Required: in_rdy=4'b0100. Next cycle out_val=1, out_msg=0x0000_00A5, out_src=2. Then prio_ptr=3.
- Round-robin fairness:
  - Stimulus: all four in_val held high, distinct msgs 0x10,0x11,0x12,0x13, out_rdy=1, for 8 cycles.
  - Required: out_src sequence 0,1,2,3,0,1,2,3 and out_val=1 every cycle from cycle 1.
- Backpressure:
  - Stimulus: in_val=4'b0011, out_rdy=0 after the first transfer.
  - Required: out_val=1 and out_msg/out_src stable. in_rdy=0 in every cycle after the first transfer while out_rdy=0.
  - On out_rdy=1: a transfer resumes in the same cycle, and the next winner is stream 1.
- Wrap-around and sparse requests:
  - Stimulus: prio_ptr=3 (after a grant to stream 2), in_val=4'b0011.
  - Required: winner stream 0, then prio_ptr=1, next winner stream 1.
- Bubble and drain:
  - Stimulus: one transfer, then in_val=0 with out_rdy=1.
  - Required: out_val=1 for one cycle then 0; out_msg retains its last value.
- Each scenario runs at p_nbits=32, p_nreqs=4 and repeats at p_nreqs=2 and p_nreqs=5 (non-power-of-two wrap at index 4).
